// File: rtl/kbd_event_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : kbd_pkg                                                |
// | Description : Shared definitions for the keyboard event controller:  |
// |               scan-code byte constants, sequencer state encoding,    |
// |               the packed queue entry and the modifier update helper. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package kbd_pkg;

   // Prefix bytes and modifier scan codes
   localparam logic [7:0] C_BYTE_EXT    = 8'hE0;
   localparam logic [7:0] C_BYTE_BRK    = 8'hF0;
   localparam logic [7:0] C_KEY_LSHIFT  = 8'h12;
   localparam logic [7:0] C_KEY_RSHIFT  = 8'h59;
   localparam logic [7:0] C_KEY_CTRL    = 8'h14;

   // Sequencer states (explicit 2-bit encoding)
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXT     = 2'd1,
      ST_BRK     = 2'd2,
      ST_EXT_BRK = 2'd3
   } kbd_state_t;

   // One queued key event, 20 bits
   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       rel;
      logic [7:0] ascii;
      logic       shift;
      logic       ctrl;
   } kbd_event_t;

   // Modifier bit positions: [0] lshift, [1] rshift, [2] lctrl, [3] rctrl.
   // Returns the held-modifier vector after applying one key event.
   function automatic logic [3:0] mod_update(input logic [3:0] mods,
                                             input logic [7:0] code,
                                             input logic       ext,
                                             input logic       rel);
      logic [3:0] m;
      m = mods;
      if (!ext && code == C_KEY_LSHIFT) m[0] = !rel;
      if (!ext && code == C_KEY_RSHIFT) m[1] = !rel;
      if (!ext && code == C_KEY_CTRL)   m[2] = !rel;
      if ( ext && code == C_KEY_CTRL)   m[3] = !rel;
      return m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/kbd_event_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : kbd_event_ctrl_if                                      |
// | Description : Scan-code input strobe and event-queue output bundle.  |
// |               master : the controller (consumes bytes, drives queue) |
// |               slave  : the byte source / event consumer side         |
// |   sc_data/sc_valid  scan byte + one-cycle strobe                     |
// |   ev_valid/ev_ready queue head handshake                             |
// |   ev_code/ev_ext/ev_release/ev_ascii/ev_shift/ev_ctrl  head fields   |
// |   ev_count          queued entries                                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface kbd_event_ctrl_if #(
   parameter int FIFO_DEPTH = 8
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [7:0]    sc_data;
   logic          sc_valid;
   logic          ev_valid;
   logic          ev_ready;
   logic [7:0]    ev_code;
   logic          ev_ext;
   logic          ev_release;
   logic [7:0]    ev_ascii;
   logic          ev_shift;
   logic          ev_ctrl;
   logic [CW-1:0] ev_count;

   modport master (
      input  sc_data, sc_valid, ev_ready,
      output ev_valid, ev_code, ev_ext, ev_release, ev_ascii,
             ev_shift, ev_ctrl, ev_count
   );

   modport slave (
      output sc_data, sc_valid, ev_ready,
      input  ev_valid, ev_code, ev_ext, ev_release, ev_ascii,
             ev_shift, ev_ctrl, ev_count
   );
endinterface
`default_nettype wire

// File: rtl/kbd_event_ctrl_ascii_lut.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : kbd_ascii_lut                                          |
// | Description : Combinational scan-code (set 2) to ASCII map for       |
// |               non-extended presses.                                  |
// |   code  in  8  scan code                                             |
// |   shift in  1  shift held (uppercases letters only)                  |
// |   ascii out 8  ASCII, 0x00 when unmapped                             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module kbd_ascii_lut (
   input  logic [7:0] code,
   input  logic       shift,
   output logic [7:0] ascii
);

   logic [7:0] w_base;
   logic       w_is_letter;

   always_comb begin
      w_base      = 8'h00;
      w_is_letter = 1'b0;
      case (code)
         // digits: unaffected by shift
         8'h16: w_base = 8'h31;
         8'h1E: w_base = 8'h32;
         8'h26: w_base = 8'h33;
         8'h25: w_base = 8'h34;
         8'h2E: w_base = 8'h35;
         8'h36: w_base = 8'h36;
         8'h3D: w_base = 8'h37;
         8'h3E: w_base = 8'h38;
         8'h46: w_base = 8'h39;
         8'h45: w_base = 8'h30;
         // letters: lowercase base
         8'h1C: begin w_base = 8'h61; w_is_letter = 1'b1; end
         8'h32: begin w_base = 8'h62; w_is_letter = 1'b1; end
         8'h21: begin w_base = 8'h63; w_is_letter = 1'b1; end
         8'h23: begin w_base = 8'h64; w_is_letter = 1'b1; end
         8'h24: begin w_base = 8'h65; w_is_letter = 1'b1; end
         8'h2B: begin w_base = 8'h66; w_is_letter = 1'b1; end
         8'h34: begin w_base = 8'h67; w_is_letter = 1'b1; end
         8'h33: begin w_base = 8'h68; w_is_letter = 1'b1; end
         8'h43: begin w_base = 8'h69; w_is_letter = 1'b1; end
         8'h3B: begin w_base = 8'h6A; w_is_letter = 1'b1; end
         8'h42: begin w_base = 8'h6B; w_is_letter = 1'b1; end
         8'h4B: begin w_base = 8'h6C; w_is_letter = 1'b1; end
         8'h3A: begin w_base = 8'h6D; w_is_letter = 1'b1; end
         8'h31: begin w_base = 8'h6E; w_is_letter = 1'b1; end
         8'h44: begin w_base = 8'h6F; w_is_letter = 1'b1; end
         8'h4D: begin w_base = 8'h70; w_is_letter = 1'b1; end
         8'h15: begin w_base = 8'h71; w_is_letter = 1'b1; end
         8'h2D: begin w_base = 8'h72; w_is_letter = 1'b1; end
         8'h1B: begin w_base = 8'h73; w_is_letter = 1'b1; end
         8'h2C: begin w_base = 8'h74; w_is_letter = 1'b1; end
         8'h3C: begin w_base = 8'h75; w_is_letter = 1'b1; end
         8'h2A: begin w_base = 8'h76; w_is_letter = 1'b1; end
         8'h1D: begin w_base = 8'h77; w_is_letter = 1'b1; end
         8'h22: begin w_base = 8'h78; w_is_letter = 1'b1; end
         8'h35: begin w_base = 8'h79; w_is_letter = 1'b1; end
         8'h1A: begin w_base = 8'h7A; w_is_letter = 1'b1; end
         // whitespace / control
         8'h29: w_base = 8'h20;
         8'h5A: w_base = 8'h0D;
         default: w_base = 8'h00;
      endcase
   end

   assign ascii = (w_is_letter && shift) ? (w_base - 8'h20) : w_base;

endmodule
`default_nettype wire

// File: rtl/kbd_event_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : kbd_event_ctrl                                         |
// | Description : PS/2 scan-code sequencer and event queue. Collapses    |
// |               make/break/extended byte sequences into single events, |
// |               tracks shift/ctrl, translates presses to ASCII and     |
// |               buffers events in a FIFO drained by valid/ready.       |
// |   clk           in   clock                                           |
// |   rst           in   synchronous reset, active low                   |
// |   bus           if   kbd_event_ctrl_if.master (bytes in, events out) |
// |   overflow      out  sticky: an event was dropped on a full queue    |
// |   clr_overflow  in   clears overflow (a same-cycle drop wins)        |
// |   press_count   out  accepted press events, wraps at 8 bits          |
// | Option      : KBD_TYPEMATIC_FILTER_EN - suppress auto-repeat presses |
// |               of the key currently held.                             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module kbd_event_ctrl
   import kbd_pkg::*;
#(
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 65535
)(
   input  logic                  clk,
   input  logic                  rst,
   kbd_event_ctrl_if.master      bus,
   output logic                  overflow,
   input  logic                  clr_overflow,
   output logic [7:0]            press_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   // ---------------- sequencer ----------------
   kbd_state_t   r_state;
   logic [TW-1:0] r_timeout;

   logic         w_emit;
   logic         w_ext;
   logic         w_rel;

   // Decode the byte completing a sequence in the current state
   always_comb begin
      w_emit = 1'b0;
      w_ext  = 1'b0;
      w_rel  = 1'b0;
      if (bus.sc_valid) begin
         case (r_state)
            ST_IDLE: begin
               if (bus.sc_data != C_BYTE_EXT && bus.sc_data != C_BYTE_BRK)
                  w_emit = 1'b1;
            end
            ST_EXT: begin
               if (bus.sc_data != C_BYTE_EXT && bus.sc_data != C_BYTE_BRK) begin
                  w_emit = 1'b1;
                  w_ext  = 1'b1;
               end
            end
            ST_BRK: begin
               w_emit = 1'b1;
               w_rel  = 1'b1;
            end
            ST_EXT_BRK: begin
               w_emit = 1'b1;
               w_ext  = 1'b1;
               w_rel  = 1'b1;
            end
            default: w_emit = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_timeout <= '0;
      end else if (bus.sc_valid) begin
         r_timeout <= '0;
         case (r_state)
            ST_IDLE: begin
               if (bus.sc_data == C_BYTE_EXT)      r_state <= ST_EXT;
               else if (bus.sc_data == C_BYTE_BRK) r_state <= ST_BRK;
               else                                r_state <= ST_IDLE;
            end
            ST_EXT: begin
               if (bus.sc_data == C_BYTE_BRK)      r_state <= ST_EXT_BRK;
               else if (bus.sc_data == C_BYTE_EXT) r_state <= ST_EXT;
               else                                r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end else if (r_state != ST_IDLE) begin
         // Abandon a dangling prefix once the idle gap reaches the limit
         if (r_timeout == TW'(TIMEOUT_CYCLES - 1)) begin
            r_state   <= ST_IDLE;
            r_timeout <= '0;
         end else begin
            r_timeout <= r_timeout + 1'b1;
         end
      end
   end

   // ---------------- modifiers and translation ----------------
   logic [3:0]   r_mods;
   logic [3:0]   w_mods_nxt;
   logic         w_shift;
   logic         w_ctrl;
   logic [7:0]   w_lut_ascii;
   logic [7:0]   w_ascii;

   // Reported modifier state includes the effect of the event itself
   assign w_mods_nxt = mod_update(r_mods, bus.sc_data, w_ext, w_rel);
   assign w_shift    = w_mods_nxt[0] | w_mods_nxt[1];
   assign w_ctrl     = w_mods_nxt[2] | w_mods_nxt[3];

   kbd_ascii_lut u_ascii_lut (
      .code  (bus.sc_data),
      .shift (w_shift),
      .ascii (w_lut_ascii)
   );

   assign w_ascii = (w_ext || w_rel) ? 8'h00 : w_lut_ascii;

   // ---------------- typematic filter ----------------
   logic         w_repeat;

`ifdef KBD_TYPEMATIC_FILTER_EN
   logic [7:0]   r_last_code;
   logic         r_last_ext;
   logic         r_last_vld;

   assign w_repeat = w_emit && !w_rel && r_last_vld &&
                     (r_last_code == bus.sc_data) && (r_last_ext == w_ext);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_last_code <= '0;
         r_last_ext  <= 1'b0;
         r_last_vld  <= 1'b0;
      end else if (w_emit) begin
         if (w_rel) begin
            r_last_vld <= 1'b0;
         end else begin
            r_last_code <= bus.sc_data;
            r_last_ext  <= w_ext;
            r_last_vld  <= 1'b1;
         end
      end
   end
`else
   assign w_repeat = 1'b0;
`endif

   // ---------------- event queue ----------------
   kbd_event_t   r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic         r_overflow;
   logic [7:0]   r_press_count;

   kbd_event_t   w_entry;
   kbd_event_t   w_head;
   logic         w_push_req;
   logic         w_full;
   logic         w_pop;
   logic         w_push_ok;
   logic         w_drop;

   assign w_entry    = '{code: bus.sc_data, ext: w_ext, rel: w_rel,
                         ascii: w_ascii, shift: w_shift, ctrl: w_ctrl};
   assign w_push_req = w_emit && !w_repeat;
   assign w_full     = (r_count == CW'(FIFO_DEPTH));
   assign w_pop      = (r_count != '0) && bus.ev_ready;
   // A pop in the same cycle frees the slot the push needs
   assign w_push_ok  = w_push_req && (!w_full || w_pop);
   assign w_drop     = w_push_req && w_full && !w_pop;

   always_ff @(posedge clk) begin
      if (w_push_ok)
         r_mem[r_wr_ptr] <= w_entry;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_mods        <= '0;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_overflow    <= 1'b0;
         r_press_count <= '0;
      end else begin
         if (w_emit)
            r_mods <= w_mods_nxt;

         if (w_push_ok)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;

         case ({w_push_ok, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase

         if (w_drop)
            r_overflow <= 1'b1;
         else if (clr_overflow)
            r_overflow <= 1'b0;

         if (w_push_ok && !w_rel)
            r_press_count <= r_press_count + 1'b1;
      end
   end

   // Head fields read as zero while the queue is empty
   assign w_head = (r_count != '0) ? r_mem[r_rd_ptr] : '0;

   assign bus.ev_valid   = (r_count != '0);
   assign bus.ev_code    = w_head.code;
   assign bus.ev_ext     = w_head.ext;
   assign bus.ev_release = w_head.rel;
   assign bus.ev_ascii   = w_head.ascii;
   assign bus.ev_shift   = w_head.shift;
   assign bus.ev_ctrl    = w_head.ctrl;
   assign bus.ev_count   = r_count;

   assign overflow    = r_overflow;
   assign press_count = r_press_count;

endmodule
`default_nettype wire

// File: tb/tb_kbd_event_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_kbd_event_ctrl                                      |
// | Description : Directed self-checking bench for kbd_event_ctrl.       |
// |               Inputs change just after the falling edge, outputs are |
// |               sampled there too, so the rising edge sits mid-cycle.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_kbd_event_ctrl;

   localparam int DEPTH   = 8;
   localparam int TIMEOUT = 20;

   logic       clk;
   logic       rst;
   logic       overflow;
   logic       clr_overflow;
   logic [7:0] press_count;

   int n_checks;
   int n_errors;

   kbd_event_ctrl_if #(.FIFO_DEPTH(DEPTH)) bus ();

   kbd_event_ctrl #(
      .FIFO_DEPTH     (DEPTH),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .overflow     (overflow),
      .clr_overflow (clr_overflow),
      .press_count  (press_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Byte is sampled by the rising edge inside this call; returns on the next falling edge
   task automatic send(input logic [7:0] b);
      bus.sc_data  = b;
      bus.sc_valid = 1'b1;
      tick();
      bus.sc_valid = 1'b0;
   endtask

   // Check the head {valid, code, ext, rel, ascii, shift, ctrl} then pop it
   task automatic pop_ev(input string tag, input logic [7:0] code, input logic ext,
                         input logic rel, input logic [7:0] ascii,
                         input logic shift, input logic ctrl);
      chk(tag, {11'd0, bus.ev_valid, bus.ev_code, bus.ev_ext, bus.ev_release,
                bus.ev_ascii, bus.ev_shift, bus.ev_ctrl},
               {11'd0, 1'b1, code, ext, rel, ascii, shift, ctrl});
      bus.ev_ready = 1'b1;
      tick();
      bus.ev_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
   endtask

   initial begin
      n_checks     = 0;
      n_errors     = 0;
      rst          = 1'b0;
      clr_overflow = 1'b0;
      bus.sc_data  = 8'h00;
      bus.sc_valid = 1'b0;
      bus.ev_ready = 1'b0;
      tick();
      do_reset();

      // ---- reset state ----
      chk("rst_valid",  {31'd0, bus.ev_valid}, 32'd0);
      chk("rst_count",  {28'd0, bus.ev_count}, 32'd0);
      chk("rst_ovf",    {31'd0, overflow}, 32'd0);
      chk("rst_pcnt",   {24'd0, press_count}, 32'd0);
      chk("rst_data",   {14'd0, bus.ev_code, bus.ev_ext, bus.ev_release,
                         bus.ev_ascii, bus.ev_shift, bus.ev_ctrl}, 32'd0);
      // ready with empty queue is ignored
      bus.ev_ready = 1'b1;
      tick();
      bus.ev_ready = 1'b0;
      chk("empty_pop_count", {28'd0, bus.ev_count}, 32'd0);

      // ---- simple press / release, one-cycle latency ----
      send(8'h1C);
      chk("lat_valid", {31'd0, bus.ev_valid}, 32'd1);
      chk("lat_count", {28'd0, bus.ev_count}, 32'd1);
      send(8'hF0);
      send(8'h1C);
      chk("pr_count",  {28'd0, bus.ev_count}, 32'd2);
      tick();
      tick();
      pop_ev("a_press",   8'h1C, 1'b0, 1'b0, 8'h61, 1'b0, 1'b0);
      pop_ev("a_release", 8'h1C, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      chk("pr_drained", {31'd0, bus.ev_valid}, 32'd0);
      chk("pr_pcnt",    {24'd0, press_count}, 32'd1);

      // ---- shift handling ----
      send(8'h12);
      send(8'h1C);
      send(8'hF0); send(8'h1C);
      send(8'hF0); send(8'h12);
      send(8'h1C);
      pop_ev("lsh_press",   8'h12, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      pop_ev("A_press",     8'h1C, 1'b0, 1'b0, 8'h41, 1'b1, 1'b0);
      pop_ev("A_release",   8'h1C, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
      pop_ev("lsh_release", 8'h12, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      pop_ev("a2_press",    8'h1C, 1'b0, 1'b0, 8'h61, 1'b0, 1'b0);
      chk("sh_pcnt", {24'd0, press_count}, 32'd4);

      // ---- extended sequences, back-to-back bytes ----
      send(8'hE0); send(8'h14);
      send(8'hE0); send(8'hF0); send(8'h14);
      send(8'hE0); send(8'h75);
      chk("ext_count", {28'd0, bus.ev_count}, 32'd3);
      pop_ev("rctl_press",   8'h14, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
      pop_ev("rctl_release", 8'h14, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
      pop_ev("up_press",     8'h75, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      chk("ext_pcnt", {24'd0, press_count}, 32'd6);

      // ---- overflow: eight fit, ninth dropped ----
      send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
      send(8'h2E); send(8'h36); send(8'h3D); send(8'h3E);
      chk("full_count", {28'd0, bus.ev_count}, 32'd8);
      chk("full_ovf0",  {31'd0, overflow}, 32'd0);
      send(8'h46);
      chk("drop_count", {28'd0, bus.ev_count}, 32'd8);
      chk("drop_ovf",   {31'd0, overflow}, 32'd1);
      chk("drop_pcnt",  {24'd0, press_count}, 32'd14);
      // push + pop on a full queue: push accepted, count unchanged
      chk("fullpp_head", {16'd0, bus.ev_code, bus.ev_ascii}, {16'd0, 8'h16, 8'h31});
      bus.sc_data  = 8'h45;
      bus.sc_valid = 1'b1;
      bus.ev_ready = 1'b1;
      tick();
      bus.sc_valid = 1'b0;
      bus.ev_ready = 1'b0;
      chk("fullpp_count", {28'd0, bus.ev_count}, 32'd8);
      chk("fullpp_pcnt",  {24'd0, press_count}, 32'd15);
      pop_ev("d2", 8'h1E, 1'b0, 1'b0, 8'h32, 1'b0, 1'b0);
      pop_ev("d3", 8'h26, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0);
      pop_ev("d4", 8'h25, 1'b0, 1'b0, 8'h34, 1'b0, 1'b0);
      pop_ev("d5", 8'h2E, 1'b0, 1'b0, 8'h35, 1'b0, 1'b0);
      pop_ev("d6", 8'h36, 1'b0, 1'b0, 8'h36, 1'b0, 1'b0);
      pop_ev("d7", 8'h3D, 1'b0, 1'b0, 8'h37, 1'b0, 1'b0);
      pop_ev("d8", 8'h3E, 1'b0, 1'b0, 8'h38, 1'b0, 1'b0);
      pop_ev("d0", 8'h45, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0);
      chk("drain_empty", {31'd0, bus.ev_valid}, 32'd0);
      chk("ovf_sticky",  {31'd0, overflow}, 32'd1);
      clr_overflow = 1'b1;
      tick();
      clr_overflow = 1'b0;
      chk("ovf_clr", {31'd0, overflow}, 32'd0);

      // ---- prefix timeout: one cycle short keeps EXT, full limit abandons it ----
      send(8'hE0);
      repeat (TIMEOUT - 1) tick();
      send(8'h1C);
      send(8'hE0);
      repeat (TIMEOUT) tick();
      send(8'h1C);
      pop_ev("to_short", 8'h1C, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      pop_ev("to_full",  8'h1C, 1'b0, 1'b0, 8'h61, 1'b0, 1'b0);
      chk("to_pcnt", {24'd0, press_count}, 32'd17);

      // ---- reset mid-sequence discards queue and partial break ----
      send(8'h2B);
      send(8'hF0);
      do_reset();
      chk("mrst_count", {28'd0, bus.ev_count}, 32'd0);
      chk("mrst_pcnt",  {24'd0, press_count}, 32'd0);
      send(8'h1C);
      pop_ev("mrst_press", 8'h1C, 1'b0, 1'b0, 8'h61, 1'b0, 1'b0);

      // ---- typematic repeat ----
      do_reset();
      send(8'h1C); send(8'h1C); send(8'h1C);
      send(8'hF0); send(8'h1C);
`ifdef KBD_TYPEMATIC_FILTER_EN
      chk("rep_count", {28'd0, bus.ev_count}, 32'd2);
      chk("rep_pcnt",  {24'd0, press_count}, 32'd1);
      pop_ev("rep_p1",  8'h1C, 1'b0, 1'b0, 8'h61, 1'b0, 1'b0);
      pop_ev("rep_rel", 8'h1C, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
`else
      chk("rep_count", {28'd0, bus.ev_count}, 32'd4);
      chk("rep_pcnt",  {24'd0, press_count}, 32'd3);
      pop_ev("rep_p1",  8'h1C, 1'b0, 1'b0, 8'h61, 1'b0, 1'b0);
      pop_ev("rep_p2",  8'h1C, 1'b0, 1'b0, 8'h61, 1'b0, 1'b0);
      pop_ev("rep_p3",  8'h1C, 1'b0, 1'b0, 8'h61, 1'b0, 1'b0);
      pop_ev("rep_rel", 8'h1C, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
`endif
      chk("rep_empty", {31'd0, bus.ev_valid}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
